// File: rtl/approximate_accuracy_controllable_divider_pkg.sv
// Shared definitions for the approximate accuracy-controllable divider.
//   LEN       : default operand width
//   state_t   : FSM state encoding (IDLE/CALC/DONE)
//   ER_EXACT  : accuracy mask that makes every subtractor cell exact
package approximate_accuracy_controllable_divider_pkg;

   localparam int LEN = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [LEN-2:0] ER_EXACT = '1;

endpackage

// File: rtl/approximate_controllable_subtractor.sv
// Ripple subtractor over LEN+1 cells with per-cell accuracy gating.
// Cells LEN-1 and LEN are always exact. For a lower cell k, er[k]=1 gives a
// full subtractor; er[k]=0 gives diff=a^b and kills the outgoing borrow.
// Ports:
//   a, b   : minuend / subtrahend, LEN+1 bits
//   er     : accuracy mask, LEN-1 bits
//   diff   : low LEN bits of a-b
//   borrow : borrow out of the top cell (1 means a < b under the mask)
module approximate_controllable_subtractor
#(
   parameter int LEN = 8
)
(
   input  logic [LEN:0]   a,
   input  logic [LEN:0]   b,
   input  logic [LEN-2:0] er,
   output logic [LEN-1:0] diff,
   output logic           borrow
);
   import approximate_accuracy_controllable_divider_pkg::*;

   // bc[k] is the borrow into cell k
   logic [LEN+1:0] bc;

   assign bc[0] = 1'b0;

   for (genvar k = 0; k <= LEN; k++) begin : g_cell
      if (k >= LEN-1) begin : g_exact
         assign bc[k+1] = (~a[k] & b[k]) | (~(a[k] ^ b[k]) & bc[k]);
         // The top cell's difference bit is always shifted out of the
         // partial remainder before use, so only its borrow is produced.
         if (k < LEN) begin : g_diff
            assign diff[k] = a[k] ^ b[k] ^ bc[k];
         end
      end else begin : g_ctl
         assign diff[k]  = er[k] ? (a[k] ^ b[k] ^ bc[k]) : (a[k] ^ b[k]);
         assign bc[k+1]  = er[k] & ((~a[k] & b[k]) | (~(a[k] ^ b[k]) & bc[k]));
      end
   end

   assign borrow = bc[LEN+1];

endmodule

// File: rtl/approximate_accuracy_controllable_divider.sv
// Sequential radix-2 restoring divider with run-time accuracy control.
// One quotient bit per cycle, MSB first; the partial-remainder subtractor is
// gated per cell by the latched Er mask.
// Optional feature macro: DIVIDER_EARLY_OUT_EN -- when defined, a nonzero
// divisor larger than the dividend skips CALC (Q=0, R=Dividend next cycle).
// Ports:
//   CLK, reset        : clock, synchronous active-high reset
//   start             : request, sampled only in IDLE
//   Er                : accuracy mask (1 = exact cell)
//   Dividend, Divisor : unsigned operands
//   busy              : high while computing
//   valid             : one-cycle result strobe
//   Quotient, Remainder, div_by_zero : results, held until the next start
module approximate_accuracy_controllable_divider
#(
   parameter int LEN = approximate_accuracy_controllable_divider_pkg::LEN
)
(
   input  logic           CLK,
   input  logic           reset,
   input  logic           start,
   input  logic [LEN-2:0] Er,
   input  logic [LEN-1:0] Dividend,
   input  logic [LEN-1:0] Divisor,
   output logic           busy,
   output logic           valid,
   output logic [LEN-1:0] Quotient,
   output logic [LEN-1:0] Remainder,
   output logic           div_by_zero
);
   import approximate_accuracy_controllable_divider_pkg::*;

   localparam int             CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN-1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [LEN-1:0]   dvd_sh;   // dividend, consumed MSB first
   logic [LEN-1:0]   dvs_r;
   logic [LEN-2:0]   er_r;
   logic [LEN-1:0]   p_r;      // partial remainder (bit LEN never survives a shift)
   logic [LEN-1:0]   q_sh;

   logic [LEN:0]     p_shift;
   logic [LEN-1:0]   d_sub;
   logic             sub_borrow;
   logic [LEN-1:0]   p_next;
   logic [LEN-1:0]   q_next;
   logic             early_out;

   assign p_shift = {p_r, dvd_sh[LEN-1]};

   approximate_controllable_subtractor #(.LEN(LEN)) u_sub (
      .a      (p_shift),
      .b      ({1'b0, dvs_r}),
      .er     (er_r),
      .diff   (d_sub),
      .borrow (sub_borrow)
   );

   // Restore on borrow: keep the shifted remainder, quotient bit 0
   assign p_next = sub_borrow ? p_shift[LEN-1:0] : d_sub;
   assign q_next = {q_sh[LEN-2:0], ~sub_borrow};

`ifdef DIVIDER_EARLY_OUT_EN
   assign early_out = (Divisor != '0) && (Dividend < Divisor);
`else
   assign early_out = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         dvd_sh      <= '0;
         dvs_r       <= '0;
         er_r        <= '0;
         p_r         <= '0;
         q_sh        <= '0;
         busy        <= 1'b0;
         valid       <= 1'b0;
         Quotient    <= '0;
         Remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               valid <= 1'b0;
               if (start) begin
                  dvd_sh <= Dividend;
                  dvs_r  <= Divisor;
                  er_r   <= Er;
                  p_r    <= '0;
                  q_sh   <= '0;
                  cnt    <= '0;
                  if (Divisor == '0) begin
                     state       <= DONE;
                     valid       <= 1'b1;
                     Quotient    <= '1;
                     Remainder   <= Dividend;
                     div_by_zero <= 1'b1;
                  end else if (early_out) begin
                     state       <= DONE;
                     valid       <= 1'b1;
                     Quotient    <= '0;
                     Remainder   <= Dividend;
                     div_by_zero <= 1'b0;
                  end else begin
                     state       <= CALC;
                     busy        <= 1'b1;
                     Quotient    <= '0;
                     Remainder   <= '0;
                     div_by_zero <= 1'b0;
                  end
               end
            end
            CALC: begin
               p_r    <= p_next;
               q_sh   <= q_next;
               dvd_sh <= dvd_sh << 1;
               cnt    <= cnt + 1'b1;
               // Final step lands directly in the output registers so valid
               // rises the cycle after the last step.
               if (cnt == LAST) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  valid     <= 1'b1;
                  Quotient  <= q_next;
                  Remainder <= p_next;
               end
            end
            DONE: begin
               valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_approximate_accuracy_controllable_divider.sv
module tb_approximate_accuracy_controllable_divider;
   import approximate_accuracy_controllable_divider_pkg::*;

   localparam int W = 8;
`ifdef DIVIDER_EARLY_OUT_EN
   localparam bit EO = 1'b1;
`else
   localparam bit EO = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } exp_t;

   logic           CLK = 1'b0;
   logic           reset;
   logic           start;
   logic [W-2:0]   Er;
   logic [W-1:0]   Dividend, Divisor;
   logic           busy, valid, div_by_zero;
   logic [W-1:0]   Quotient, Remainder;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   always #5 CLK = ~CLK;

   approximate_accuracy_controllable_divider #(.LEN(W)) dut (
      .CLK         (CLK),
      .reset       (reset),
      .start       (start),
      .Er          (Er),
      .Dividend    (Dividend),
      .Divisor     (Divisor),
      .busy        (busy),
      .valid       (valid),
      .Quotient    (Quotient),
      .Remainder   (Remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Restoring division with a bit-level approximate subtractor model
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-2:0] er);
      exp_t        e;
      logic [W:0]  p, pp, d, bb;
      logic [W:0]  er9;
      logic        bw, ai, bi;
      e = '0;
      if (b == 0) begin
         e.q = '1; e.r = a; e.dbz = 1'b1;
         return e;
      end
      if (EO && a < b) begin
         e.r = a;
         return e;
      end
      er9 = {2'b11, er};
      bb  = {1'b0, b};
      p   = '0;
      for (int i = W-1; i >= 0; i--) begin
         pp = {p[W-1:0], a[i]};
         bw = 1'b0;
         d  = '0;
         for (int k = 0; k <= W; k++) begin
            ai = pp[k];
            bi = bb[k];
            if (er9[k]) begin
               d[k] = ai ^ bi ^ bw;
               bw   = (!ai && bi) || (!(ai ^ bi) && bw);
            end else begin
               d[k] = ai ^ bi;
               bw   = 1'b0;
            end
         end
         if (!bw) begin
            p      = d;
            e.q[i] = 1'b1;
         end else begin
            p = pp;
         end
      end
      e.r = p[W-1:0];
      return e;
   endfunction

   // Scoreboard compare: every valid strobe must match the oldest expectation
   always @(negedge CLK) begin
      exp_t e;
      if (!reset && valid) begin
         chk("busy_with_valid", busy, 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", valid, 0);
         end else begin
            e = exp_q.pop_front();
            chk("quotient", Quotient, e.q);
            chk("remainder", Remainder, e.r);
            chk("div_by_zero", div_by_zero, e.dbz);
         end
      end
   end

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-2:0] er, input int poke);
      int cyc, bcnt;
      bit shortp;
      shortp = (b == 0) || (EO && a < b);
      @(negedge CLK);
      Dividend = a; Divisor = b; Er = er; start = 1'b1;
      exp_q.push_back(model(a, b, er));
      @(negedge CLK);
      start = 1'b0;
      cyc = 1; bcnt = 0;
      while (!valid && cyc < 30) begin
         bcnt += int'(busy);
         if (cyc == poke) begin
            start = 1'b1; Dividend = ~a; Divisor = 8'd3; Er = '0;
         end else begin
            start = 1'b0;
         end
         @(negedge CLK);
         cyc++;
      end
      start = 1'b0;
      chk("latency", cyc, shortp ? 1 : W+1);
      chk("busy_cycles", bcnt, shortp ? 0 : W);
   endtask

   initial begin
      exp_t e;
      logic [W-1:0] a, b;
      bit vseen;

      reset = 1'b1; start = 1'b0; Er = '0; Dividend = '0; Divisor = '0;
      repeat (3) @(negedge CLK);
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      chk("rst_quotient", Quotient, 0);
      chk("rst_remainder", Remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      reset = 1'b0;

      // Hand-computed pins on the model itself
      e = model(8'd200, 8'd7, ER_EXACT);
      chk("model_200_7", {e.q, e.r}, {8'd28, 8'd4});
      e = model(8'd15, 8'd3, 7'h00);
      chk("model_15_3_er0", {e.q, e.r}, {8'hFF, 8'h0E});
      e = model(8'h55, 8'd0, ER_EXACT);
      chk("model_dbz", {e.q, e.r, e.dbz}, {8'hFF, 8'h55, 1'b1});

      run_op(8'd200, 8'd7, ER_EXACT, 0);
      run_op(8'h55, 8'd0, ER_EXACT, 0);

      for (int i = 0; i < 20; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(1, 255));
         e = model(a, b, ER_EXACT);
         chk("model_exact", {e.q, e.r}, {a / b, a % b});
         run_op(a, b, ER_EXACT, 0);
      end

      run_op(8'd15, 8'd3, 7'h00, 0);
      for (int i = 0; i < 100; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(1, 255));
         run_op(a, b, (i < 50) ? 7'h00 : 7'h0F, 0);
      end

      // Start pulsed mid-operation with other operands must be ignored
      run_op(8'd200, 8'd7, ER_EXACT, 3);
      repeat (12) @(negedge CLK);

      // Reset while results are holding clears them
      repeat (2) @(negedge CLK);
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
      chk("hold_rst_quotient", Quotient, 0);
      chk("hold_rst_remainder", Remainder, 0);

      // Reset mid-operation aborts with no result strobe
      Dividend = 8'd200; Divisor = 8'd7; Er = ER_EXACT; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (3) @(negedge CLK);
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_valid", valid, 0);
      chk("abort_quotient", Quotient, 0);
      chk("abort_remainder", Remainder, 0);
      chk("abort_dbz", div_by_zero, 0);
      vseen = 1'b0;
      repeat (12) begin
         @(negedge CLK);
         vseen |= valid;
      end
      chk("abort_no_valid", vseen, 0);

      run_op(8'd5, 8'd9, ER_EXACT, 0);
      repeat (3) @(negedge CLK);
      chk("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/approximate_accuracy_controllable_divider.md
# approximate_accuracy_controllable_divider

Sequential radix-2 restoring divider whose partial-remainder subtractor has run-time controllable accuracy through a per-bit error-control mask `Er`. It is the inverse-operation counterpart of the approximate accuracy-controllable multiplier in the approximate arithmetic unit set. It accepts an operand pair on a start strobe and returns quotient and remainder after a fixed number of cycles. Lower-accuracy settings shorten borrow chains, trading exactness for energy.

## Interface
- `LEN`, 8, operand width; `Er` width is `LEN-1`.
- `CLK` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request; sampled only in IDLE.
- `Er` input LEN-1: accuracy mask; bit k = 1 makes subtractor cell k exact, 0 makes it approximate.
- `Dividend` input LEN: unsigned dividend.
- `Divisor` input LEN: unsigned divisor.
- `busy` output 1: high in CALC.
- `valid` output 1: one-cycle result strobe.
- `Quotient` output LEN: result quotient.
- `Remainder` output LEN: result remainder.
- `div_by_zero` output 1: set with `valid` when `Divisor` was 0.

## Operation
- States: IDLE, CALC, DONE. All outputs reset to 0; state resets to IDLE; counter resets to 0.
- IDLE with `start`=1: latch `Dividend`, `Divisor`, `Er`; clear partial remainder P (LEN+1 bits).
  - If `Divisor`=0, go to DONE with Q = all ones, R = Dividend, `div_by_zero`=1.
  - Otherwise go to CALC with counter 0.
- CALC step, one quotient bit per cycle, MSB first:
  - Form P' = {P[LEN-1:0], next dividend bit} and D = approx_sub(P', {0, divisor}).
  - If the final borrow is 0: P = D, q bit = 1. Otherwise P = P', q bit = 0.
  - After LEN steps, go to DONE.
- approx_sub: cells LEN-1 and LEN are always exact. For k < LEN-1:
  - Er[k]=1: full subtractor.
  - Er[k]=0: diff = a^b, borrow-out forced 0.
  - All-ones `Er` gives the exact quotient and remainder.
- DONE: `Quotient`/`Remainder` registered; `valid`=1 for exactly one cycle, then IDLE. Results and `div_by_zero` hold until the next accepted start, when they clear.
- `start` in CALC or DONE is ignored and not queued. Inputs changing mid-operation have no effect.
- `reset` mid-operation aborts to IDLE, with outputs 0 on the following cycle.

## Timing
- Start sampled at edge 0. `busy`=1 from edge 0 through edge LEN-1, i.e. LEN cycles.
- Normal latency: `valid` high in the cycle after edge LEN, i.e. LEN+1 cycles after the start edge.
- Divide-by-zero (and early-out when enabled): `valid` high 1 cycle after the start edge; `busy` never asserts.
- Back-to-back: the earliest next start is accepted in the cycle after `valid`. Minimum initiation interval is LEN+2 cycles.
- `busy` and `valid` are never high together.

## Configuration
- `DIVIDER_EARLY_OUT_EN`
  - Defined: in IDLE, if Divisor≠0 and Dividend < Divisor (exact compare), skip CALC. DONE occurs next cycle with Q=0, R=Dividend.
  - Undefined: every nonzero-divisor operation takes the full LEN-step path. The results are identical under exact `Er`.

## Structure
- Shared package holds:
  - `LEN` default;
  - state encoding constants IDLE/CALC/DONE;
  - exact mask constant `ER_EXACT` (all ones).
- Sub-module `approximate_controllable_subtractor`: LEN+1-bit ripple subtractor with per-cell `Er` gating. It is combinational and instantiated once in the datapath.
- The top level contains the FSM, counter, shift registers and output registers.

## Test plan
- Er=7F, 200/7 → Q=28, R=4, `div_by_zero`=0; `valid` exactly 9 cycles after start; `busy` high 8 cycles.
- Er=7F, 20 random pairs with nonzero divisor → Q and R equal exact integer division.
- Divisor=0, Dividend=0x55 → Q=0xFF, R=0x55, `div_by_zero`=1; `valid` 1 cycle after start.
- Er=0x00 and Er=0x0F, 50 random pairs → Q and R match a bit-accurate software model of approx_sub.
- Start pulsed at cycle 3 of a 200/7 op → ignored; single result 28/4. `reset` at cycle 4 of another op → `busy`=0, `valid` never pulses, outputs 0.
- 5/9 with `DIVIDER_EARLY_OUT_EN` → Q=0, R=5, `valid` after 1 cycle; without the macro → same result after 9 cycles.
